// File: rtl/gpu_mem_agg_pkg.sv
// Shared sizing and state encoding for the GPU memory byte-stream aggregator.
package gpu_mem_agg_pkg;
  localparam int WORD_W     = 16;
  localparam int BYTE_W     = 8;
  localparam int NUM_WORDS  = 8;
  localparam int BEAT_BYTES = 2 * NUM_WORDS;
  localparam int CNT_W      = $clog2(BEAT_BYTES + 1);
  localparam int PAYLOAD_W  = NUM_WORDS * WORD_W;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } agg_state_e;
endpackage

// File: rtl/gpu_mem_agg_out_slot.sv
// Single-entry valid/ready output register: loads a finished beat, holds it
// under backpressure and drains it when downstream accepts.
module gpu_mem_agg_out_slot
  import gpu_mem_agg_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_payload,
  input  logic [CNT_W-1:0]     load_bytes,
  input  logic                 load_err,
  output logic                 slot_free,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     out_bytes,
  output logic                 out_err
);
  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [CNT_W-1:0]     bytes_q, bytes_d;
  logic                 err_q, err_d;

  // Free when empty or being drained this cycle, allowing a same-cycle handoff.
  assign slot_free = ~valid_q | out_ready;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    bytes_d   = bytes_q;
    err_d     = err_q;
    if (load) begin
      valid_d   = 1'b1;
      payload_d = load_payload;
      bytes_d   = load_bytes;
      err_d     = load_err;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      bytes_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      bytes_q   <= bytes_d;
      err_q     <= err_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign out_bytes   = bytes_q;
  assign out_err     = err_q;
endmodule

// File: rtl/gpu_mem_aggregator_32b.sv
// Packs a one-byte-per-beat stream into NUM_WORDS x 16-bit payload beats,
// byte 2k into word k high half and byte 2k+1 into the low half.
//
//   state   | meaning
//   FILL    | accepting bytes into the accumulator (in_ready=1)
//   PENDING | accumulator complete, waiting for the output slot (in_ready=0)
module gpu_mem_aggregator_32b
  import gpu_mem_agg_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_data,
  input  logic                 io_in_last,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [PAYLOAD_W-1:0] io_out_payload,
  output logic [CNT_W-1:0]     io_out_bytes,
  output logic                 io_out_err
);
  agg_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] acc_q, acc_d;
  logic                 acc_err_q, acc_err_d;

  logic              accept;
  logic              complete;
  logic              slot_free;
  logic              load;
  logic [BYTE_W-1:0] in_byte;
  logic              in_upper_err;

  // Ready depends on state alone, so out_ready never reaches in_ready.
  assign io_in_ready  = (state_q == FILL);
  assign accept       = io_in_valid & io_in_ready;
  assign in_byte      = io_in_data[BYTE_W-1:0];
  assign in_upper_err = |io_in_data[WORD_W-1:BYTE_W];
  assign complete     = accept & (io_in_last | (cnt_q == CNT_W'(BEAT_BYTES - 1)));
  assign load         = (state_q == PENDING) & slot_free;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_err_d = acc_err_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(2 * k))
              acc_d[k*WORD_W+BYTE_W +: BYTE_W] = in_byte;
            if (cnt_q == CNT_W'(2 * k + 1))
              acc_d[k*WORD_W +: BYTE_W] = in_byte;
          end
          cnt_d     = cnt_q + CNT_W'(1);
          acc_err_d = acc_err_q | in_upper_err;
          if (complete) state_d = PENDING;
        end
      end
      PENDING: begin
        if (slot_free) begin
          acc_d     = '0;
          cnt_d     = '0;
          acc_err_d = 1'b0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_err_q <= acc_err_d;
    end
  end

  // In PENDING the counter already holds the beat's byte count.
  gpu_mem_agg_out_slot u_out_slot (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (load),
    .load_payload (acc_q),
    .load_bytes   (cnt_q),
    .load_err     (acc_err_q),
    .slot_free    (slot_free),
    .out_valid    (io_out_valid),
    .out_ready    (io_out_ready),
    .out_payload  (io_out_payload),
    .out_bytes    (io_out_bytes),
    .out_err      (io_out_err)
  );
endmodule
